pipe_stage_buf: RTL and testbench

Parametrised pipeline-stage register with a valid/allowin handshake between two adjacent CPU stages (ID→EXE, EXE→MEM, MEM→WB). It generalises the fixed-field stage register: the payload is an opaque bus of configurable width, backpressure is supported, and an optional 2-entry skid mode breaks the combinational allowin path. It also provides flush and saturating stall/bubble counters. One instance sits at each stage boundary; the decoded-field bundles are packed into `in_data` by the producing stage.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 39 +++
 rtl/pipe_stage_buf.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_buf.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer: occupancy encoding,
// FSM state type and default payload widths for each stage boundary.
package pipe_pkg;

  // Occupancy encoding; the skid FSM state is stored directly in this form.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  // Default payload widths of the decoded-field bundles at each boundary.
  localparam int ID_EXE_DATA_W  = 160;
  localparam int EXE_MEM_DATA_W = 112;
  localparam int MEM_WB_DATA_W  = 70;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_TWO   = OCC_TWO
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared
// only by the synchronous active-low reset.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: add one unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/allowin handshake, optional 2-entry
// skid buffer (registered allowin), flush, and stall/bubble counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = ID_EXE_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_allowin,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_allowin,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  occ_e              state_q;
  occ_e              state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic              accept_s;
  logic              fire_s;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign accept_s  = in_valid && in_allowin && !flush;
  assign fire_s    = out_valid && out_allowin;

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] skid_d;
      logic              allowin_q;

      // EMPTY/ONE/TWO transitions; emptied entries are zeroed.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = DATA_ZERO;
          skid_d  = DATA_ZERO;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (accept_s) begin
                state_d = ST_ONE;
                main_d  = in_data;
              end else begin
                main_d  = DATA_ZERO;
              end
            end
            ST_ONE: begin
              if (accept_s && fire_s) begin
                main_d  = in_data;
              end else if (accept_s) begin
                state_d = ST_TWO;
                skid_d  = in_data;
              end else if (fire_s) begin
                state_d = ST_EMPTY;
                main_d  = DATA_ZERO;
              end else begin
                state_d = ST_ONE;
              end
            end
            ST_TWO: begin
              if (fire_s) begin
                state_d = ST_ONE;
                main_d  = skid_q;
                skid_d  = DATA_ZERO;
              end else begin
                state_d = ST_TWO;
              end
            end
            default: begin
              state_d = ST_EMPTY;
              main_d  = DATA_ZERO;
              skid_d  = DATA_ZERO;
            end
          endcase
        end
      end

      // Skid payload and registered allowin (low only while full).
      always_ff @(posedge clk) begin
        if (!resetn) begin
          skid_q    <= DATA_ZERO;
          allowin_q <= 1'b1;
        end else begin
          skid_q    <= skid_d;
          allowin_q <= (state_d != ST_TWO);
        end
      end

      assign in_allowin = allowin_q;
    end else begin : g_noskid
      // Single entry: load on accept, empty on fire without accept.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (flush) begin
          state_d = ST_EMPTY;
          main_d  = DATA_ZERO;
        end else if (accept_s) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end else if (fire_s || (state_q == ST_EMPTY)) begin
          state_d = ST_EMPTY;
          main_d  = DATA_ZERO;
        end else begin
          state_d = state_q;
        end
      end

      assign in_allowin = !out_valid || out_allowin;
    end
  endgenerate

  // Handshake core state and main payload register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      main_q  <= DATA_ZERO;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (out_valid && !out_allowin),
    .value  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (!out_valid),
    .value  (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: dut1 is the skid variant, dut0 the pass-through variant
// with 4-bit counters. Inputs change and outputs are sampled 1ns after clk rise.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        resetn;
  int          total = 0;
  int          bad = 0;

  logic        in_valid1, in_allowin1, out_valid1, out_allowin1, flush1;
  logic [15:0] in_data1, out_data1;
  logic [1:0]  occ1;
  logic [31:0] stall1, bubble1;

  logic        in_valid0, in_allowin0, out_valid0, out_allowin0, flush0;
  logic [15:0] in_data0, out_data0;
  logic [1:0]  occ0;
  logic [3:0]  stall0, bubble0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(16), .SKID(1), .CNT_W(32)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_allowin(in_allowin1),
    .in_data(in_data1), .out_valid(out_valid1), .out_allowin(out_allowin1),
    .out_data(out_data1), .flush(flush1), .occupancy(occ1),
    .stall_cnt(stall1), .bubble_cnt(bubble1)
  );

  pipe_stage_buf #(.DATA_W(16), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid0), .in_allowin(in_allowin0),
    .in_data(in_data0), .out_valid(out_valid0), .out_allowin(out_allowin0),
    .out_data(out_data0), .flush(flush0), .occupancy(occ0),
    .stall_cnt(stall0), .bubble_cnt(bubble0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with live-looking input on both instances.
    resetn = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'hAA; out_allowin1 = 1'b1; flush1 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 16'hAA; out_allowin0 = 1'b1; flush0 = 1'b0;
    tick(); tick(); tick();
    check("rst1_valid", out_valid1, 1'b0);
    check("rst1_data", out_data1, 16'h0);
    check("rst1_occ", occ1, 2'd0);
    check("rst1_allowin", in_allowin1, 1'b1);
    check("rst1_stall", stall1, 32'd0);
    check("rst1_bubble", bubble1, 32'd0);
    check("rst0_valid", out_valid0, 1'b0);
    check("rst0_data", out_data0, 16'h0);
    check("rst0_allowin", in_allowin0, 1'b1);
    check("rst0_bubble", bubble0, 4'd0);
    in_valid1 = 1'b0; in_valid0 = 1'b0;
    resetn = 1'b1;

    // Idle: 4-bit bubble counter saturates at 15, 32-bit one keeps counting.
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check("sat_bubble14", bubble0, 4'd14);
      if (i == 15) check("sat_bubble15", bubble0, 4'd15);
    end
    check("sat_bubble20", bubble0, 4'd15);
    check("idle_bubble1", bubble1, 32'd20);

    // Streaming 1..8 with out_allowin held high.
    out_allowin1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid1 = 1'b1;
      in_data1 = 16'(i);
      tick();
      check("stream_valid", out_valid1, 1'b1);
      check("stream_data", out_data1, 16'(i));
      check("stream_allowin", in_allowin1, 1'b1);
    end
    in_valid1 = 1'b0;
    tick();
    check("stream_end_valid", out_valid1, 1'b0);
    check("stream_end_data", out_data1, 16'h0);
    check("stream_stall", stall1, 32'd0);
    check("stream_bubble", bubble1, 32'd21);

    // Backpressure: 0x11 main, 0x22 skid, 0x33 held upstream.
    out_allowin1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'h11; tick();
    in_data1 = 16'h22; tick();
    in_data1 = 16'h33; tick();
    check("bp_occ", occ1, 2'd2);
    check("bp_allowin", in_allowin1, 1'b0);
    check("bp_main", out_data1, 16'h11);
    check("bp_skid_main", dut1.g_skid.skid_q, 16'h22);
    tick();
    check("bp_hold_main", out_data1, 16'h11);
    check("bp_hold_occ", occ1, 2'd2);
    check("bp_stall", stall1, 32'd3);
    out_allowin1 = 1'b1;
    tick();
    check("bp_rel_data22", out_data1, 16'h22);
    check("bp_rel_allowin", in_allowin1, 1'b1);
    tick();
    check("bp_rel_data33", out_data1, 16'h33);
    in_valid1 = 1'b0;
    tick();
    check("bp_drain_valid", out_valid1, 1'b0);
    check("bp_drain_data", out_data1, 16'h0);
    check("bp_bubble", bubble1, 32'd22);

    // Flush in TWO with a simultaneous incoming 0x44.
    out_allowin1 = 1'b0;
    in_valid1 = 1'b1; in_data1 = 16'h55; tick();
    in_data1 = 16'h66; tick();
    check("fl_pre_occ", occ1, 2'd2);
    flush1 = 1'b1; in_data1 = 16'h44; tick();
    check("fl_occ", occ1, 2'd0);
    check("fl_valid", out_valid1, 1'b0);
    check("fl_data", out_data1, 16'h0);
    check("fl_allowin", in_allowin1, 1'b1);
    check("fl_stall", stall1, 32'd5);
    check("fl_bubble", bubble1, 32'd23);
    flush1 = 1'b0; in_valid1 = 1'b0;
    tick();
    check("fl_after_valid", out_valid1, 1'b0);
    check("fl_after_data", out_data1, 16'h0);
    check("fl_after_bubble", bubble1, 32'd24);

    // Pass-through: combinational allowin follows out_allowin when full.
    out_allowin0 = 1'b0;
    in_valid0 = 1'b1; in_data0 = 16'h77;
    #1;
    check("pt_empty_allowin", in_allowin0, 1'b1);
    tick();
    check("pt_data77", out_data0, 16'h77);
    check("pt_full_allowin", in_allowin0, 1'b0);
    in_data0 = 16'h88;
    tick();
    check("pt_hold_data", out_data0, 16'h77);
    check("pt_stall", stall0, 4'd1);
    out_allowin0 = 1'b1;
    #1;
    check("pt_comb_allowin", in_allowin0, 1'b1);
    tick();
    check("pt_data88", out_data0, 16'h88);
    check("pt_valid88", out_valid0, 1'b1);
    in_valid0 = 1'b0;
    tick();
    check("pt_drain_valid", out_valid0, 1'b0);
    check("pt_drain_data", out_data0, 16'h0);
    check("pt_bubble_sat", bubble0, 4'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
